// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands and runs the start/done handshake.
// Build with ALU_SEQ_TIMEOUT_EN defined to add a watchdog on the WAIT phase.
module alu_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int TAG_W     = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [15:0]      cmd_op1,
    input  logic [7:0]       cmd_op2,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             alu_start,
    output logic [1:0]       alu_op_select,
    output logic [15:0]      alu_op1,
    output logic [7:0]       alu_op2,
    input  logic [15:0]      alu_res,
    input  logic             alu_done
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam logic [1:0] OP_DIV = 2'b11;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
        $error("alu_cmd_sequencer: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT1,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       op_mem_q  [CMD_DEPTH];
    logic [15:0]      op1_mem_q [CMD_DEPTH];
    logic [7:0]       op2_mem_q [CMD_DEPTH];
    logic [TAG_W-1:0] tag_mem_q [CMD_DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty, full, push, pop;

    logic [1:0]       head_op;
    logic [15:0]      head_op1;
    logic [7:0]       head_op2;
    logic [TAG_W-1:0] head_tag;

    logic [1:0]       op_sel_q, op_sel_d;
    logic [15:0]      op1_q, op1_d;
    logic [7:0]       op2_q, op2_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wdog_q, wdog_d;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign head_op  = op_mem_q[rd_ptr_q[AW-1:0]];
    assign head_op1 = op1_mem_q[rd_ptr_q[AW-1:0]];
    assign head_op2 = op2_mem_q[rd_ptr_q[AW-1:0]];
    assign head_tag = tag_mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q[AW-1:0]]  <= cmd_op;
            op1_mem_q[wr_ptr_q[AW-1:0]] <= cmd_op1;
            op2_mem_q[wr_ptr_q[AW-1:0]] <= cmd_op2;
            tag_mem_q[wr_ptr_q[AW-1:0]] <= cmd_tag;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        op_sel_d    = op_sel_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty && (!rsp_valid_q || rsp_ready)) begin
                    pop = 1'b1;
                    // Divide by zero is answered locally; the ALU never sees it.
                    if (head_op == OP_DIV && head_op2 == 8'd0) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 16'hFFFF;
                        rsp_err_d   = 1'b1;
                        rsp_tag_d   = head_tag;
                    end else begin
                        op_sel_d = head_op;
                        op1_d    = head_op1;
                        op2_d    = head_op2;
                        tag_d    = head_tag;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT1;
`ifdef ALU_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT1: begin
                state_d = WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                wdog_d  = wdog_q + 1'b1;
`endif
            end
            WAIT: begin
                if (alu_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_res;
                    rsp_err_d   = 1'b0;
                    rsp_tag_d   = tag_q;
                    state_d     = IDLE;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (wdog_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 16'h0000;
                    rsp_err_d   = 1'b1;
                    rsp_tag_d   = tag_q;
                    state_d     = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            op_sel_q    <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            op_sel_q    <= op_sel_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign alu_start     = (state_q == ISSUE);
    assign alu_op_select = op_sel_q;
    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a simple latency-programmable ALU model.
// Watchdog scenario is selected by ALU_SEQ_TIMEOUT_EN, matching the RTL build.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_op1 = '0;
    logic [7:0]  cmd_op2 = '0;
    logic [3:0]  cmd_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        alu_start;
    logic [1:0]  alu_op_select;
    logic [15:0] alu_op1;
    logic [7:0]  alu_op2;
    logic [15:0] alu_res;
    logic        alu_done;

    int n_checks = 0;
    int n_fail = 0;

    alu_cmd_sequencer #(.CMD_DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_op_select(alu_op_select),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_res(alu_res), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    // ALU model: done drops on start and rises mdl_lat cycles later.
    int          mdl_lat = 0;
    bit          mdl_stuck = 1'b0;
    logic [15:0] mdl_res = '0;
    logic        mdl_done = 1'b1;
    int          mdl_cnt = 0;

    assign alu_res  = mdl_res;
    assign alu_done = mdl_done && !mdl_stuck;

    function automatic logic [15:0] alu_fn(input logic [1:0] op,
                                           input logic [15:0] a,
                                           input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = a;
        sb = {{8{b[7]}}, b};
        case (op)
            2'd0: return sa + sb;
            2'd1: return sa - sb;
            2'd2: return 16'(sa * sb);
            default: return (sb == 0) ? 16'hFFFF : {8'(sa / sb), 8'(sa % sb)};
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_start) begin
            mdl_res <= alu_fn(alu_op_select, alu_op1, alu_op2);
            if (mdl_lat == 0) begin
                mdl_done <= 1'b1;
            end else begin
                mdl_done <= 1'b0;
                mdl_cnt  <= mdl_lat;
            end
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_done <= 1'b1;
        end
    end

    // Offers one command; returns at the negedge after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [15:0] a,
                            input logic [7:0] b, input logic [3:0] tag);
        int k;
        cmd_op    = op;
        cmd_op1   = a;
        cmd_op2   = b;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL push_accept tag=%0d: cmd_ready=%0b required 1", tag, cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: rsp_valid=%0b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || alu_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_start: rsp_valid=%0b alu_start=%0b required 0 0",
                     rsp_valid, alu_start);
        end
        n_checks++;
        if (rsp_data !== 16'h0 || rsp_tag !== 4'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: data=%h tag=%h err=%b required 0000 0 0",
                     rsp_data, rsp_tag, rsp_err);
        end
        n_checks++;
        if (alu_op1 !== 16'h0 || alu_op2 !== 8'h0 || alu_op_select !== 2'h0) begin
            n_fail++;
            $display("FAIL reset_operands: op1=%h op2=%h sel=%h required 0", alu_op1, alu_op2,
                     alu_op_select);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int first;
        mdl_lat = 0;
        push_cmd(2'd0, 16'd100, 8'hFD, 4'd1);
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid && first == 0) first = e;
        end
        n_checks++;
        if (first != 4) begin
            n_fail++;
            $display("FAIL add_latency: rsp_valid rose at edge %0d required 4", first);
        end
        n_checks++;
        if (rsp_data !== 16'd97 || rsp_tag !== 4'd1 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: data=%h tag=%h err=%b required 0061 1 0",
                     rsp_data, rsp_tag, rsp_err);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd97) begin
            n_fail++;
            $display("FAIL add_hold: valid=%b data=%h required 1 0061", rsp_valid, rsp_data);
        end
        drain_rsp();
    endtask

    task automatic test_mul();
        int starts;
        bit unstable;
        bit seen;
        mdl_lat = 8;
        push_cmd(2'd2, 16'd12, 8'hFB, 4'd2);
        starts = 0;
        unstable = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (alu_start) starts++;
            if (starts > 0 && (alu_op_select !== 2'd2 || alu_op1 !== 16'd12 ||
                               alu_op2 !== 8'hFB))
                unstable = 1'b1;
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mul_done: rsp_valid=%0b required 1 within 60 cycles", rsp_valid);
        end
        n_checks++;
        if (starts != 1) begin
            n_fail++;
            $display("FAIL mul_start_pulse: %0d start cycles required 1", starts);
        end
        n_checks++;
        if (unstable) begin
            n_fail++;
            $display("FAIL mul_operands_stable: changed=1 required 0");
        end
        n_checks++;
        if (rsp_data !== 16'hFFC4 || rsp_tag !== 4'd2 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result: data=%h tag=%h err=%b required ffc4 2 0",
                     rsp_data, rsp_tag, rsp_err);
        end
        drain_rsp();
    endtask

    task automatic test_div0();
        int starts;
        mdl_lat = 0;
        starts = 0;
        push_cmd(2'd3, 16'd50, 8'h00, 4'd3);
        if (alu_start) starts++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFFF || rsp_err !== 1'b1 ||
            rsp_tag !== 4'd3) begin
            n_fail++;
            $display("FAIL div0_rsp: valid=%b data=%h err=%b tag=%h required 1 ffff 1 3",
                     rsp_valid, rsp_data, rsp_err, rsp_tag);
        end
        for (int c = 0; c < 6; c++) begin
            if (alu_start) starts++;
            @(negedge clk);
        end
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL div0_no_start: %0d start cycles required 0", starts);
        end
        n_checks++;
        if (alu_op1 !== 16'd12 || alu_op_select !== 2'd2) begin
            n_fail++;
            $display("FAIL div0_operands_untouched: op1=%h sel=%h required 000c 2",
                     alu_op1, alu_op_select);
        end
        drain_rsp();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  tags [7];
        logic [15:0] datas [7];
        int got;
        mdl_lat = 0;
        rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) push_cmd(2'd0, 16'(100 + t), 8'd1, 4'(t));
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full: cmd_ready=%b required 0", cmd_ready);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stalled_head: valid=%b tag=%h ready=%b required 1 0 0",
                     rsp_valid, rsp_tag, cmd_ready);
        end
        got = 0;
        fork
            begin
                push_cmd(2'd0, 16'd105, 8'd1, 4'd5);
                push_cmd(2'd0, 16'd106, 8'd1, 4'd6);
            end
            begin
                rsp_ready = 1'b1;
                for (int c = 0; c < 200 && got < 7; c++) begin
                    if (rsp_valid) begin
                        tags[got]  = rsp_tag;
                        datas[got] = rsp_data;
                        got++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                rsp_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != 7) begin
            n_fail++;
            $display("FAIL b2b_count: %0d responses required 7", got);
        end
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (tags[i] !== 4'(i) || datas[i] !== 16'(101 + i)) begin
                n_fail++;
                $display("FAIL b2b_rsp%0d: tag=%h data=%h required %h %h", i, tags[i],
                         datas[i], 4'(i), 16'(101 + i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit stray;
        mdl_lat = 8;
        push_cmd(2'd2, 16'd7, 8'h03, 4'd5);
        push_cmd(2'd0, 16'd1, 8'h01, 4'd6);
        k = 0;
        while (!alu_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (alu_start !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: start=%b valid=%b ready=%b required 0 0 1",
                     alu_start, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid || alu_start) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin
            n_fail++;
            $display("FAIL midreset_quiet: activity=1 required 0");
        end
    endtask

    task automatic test_wait_limit();
        int n;
        int k;
        mdl_lat = 8;
        mdl_stuck = 1'b1;
        push_cmd(2'd2, 16'd12, 8'hFB, 4'd7);
        k = 0;
        while (!alu_start && k < 20) begin
            @(negedge clk);
            k++;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 65) begin
            n_fail++;
            $display("FAIL timeout_edge: rsp_valid after %0d edges required 65", n);
        end
        n_checks++;
        if (rsp_data !== 16'h0 || rsp_err !== 1'b1 || rsp_tag !== 4'd7) begin
            n_fail++;
            $display("FAIL timeout_rsp: data=%h err=%b tag=%h required 0000 1 7",
                     rsp_data, rsp_err, rsp_tag);
        end
        drain_rsp();
        mdl_stuck = 1'b0;
        mdl_lat = 0;
        push_cmd(2'd0, 16'd5, 8'd2, 4'd8);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 4 || rsp_data !== 16'd7 || rsp_err !== 1'b0 || rsp_tag !== 4'd8) begin
            n_fail++;
            $display("FAIL after_timeout_add: edges=%0d data=%h err=%b tag=%h required 4 0007 0 8",
                     n, rsp_data, rsp_err, rsp_tag);
        end
        drain_rsp();
`else
        n = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        n_checks++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL wait_forever: rsp_valid seen %0d cycles required 0", n);
        end
        mdl_stuck = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFFC4 || rsp_err !== 1'b0 ||
            rsp_tag !== 4'd7) begin
            n_fail++;
            $display("FAIL late_done: valid=%b data=%h err=%b tag=%h required 1 ffc4 0 7",
                     rsp_valid, rsp_data, rsp_err, rsp_tag);
        end
        drain_rsp();
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div0();
        test_back_to_back();
        test_reset_mid();
        test_wait_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
